// File: rtl/order_tx_arbiter.sv
// ============================================================================
// Module   : order_tx_arbiter
// Brief    : Per-channel one-entry order slots, round-robin granted onto a
//            single UART transmit interface with a tx_busy handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module order_tx_arbiter #(
    parameter int N_SYS     = 2,
    parameter int BUSY_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*N_SYS-1:0]   in_addr,
    input  logic [8*N_SYS-1:0]   in_buysell,
    input  logic [32*N_SYS-1:0]  in_timestamp,
    input  logic [N_SYS-1:0]     in_dv,
    output logic [N_SYS-1:0]     slot_full,
    output logic [7:0]           tx_addr,
    output logic [7:0]           tx_buysell,
    output logic [31:0]          tx_timestamp,
    output logic                 tx_dv,
    input  logic                 tx_busy,
    input  logic                 clr_err,
    output logic [N_SYS-1:0]     drop_err,
    output logic                 timeout_err
);

    localparam int c_PTR_W = (N_SYS > 1) ? $clog2(N_SYS) : 1;
    localparam int c_CNT_W = $clog2(BUSY_WAIT) + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_RST  = c_PTR_W'(N_SYS - 1);
    // The counter is checked before incrementing, so the last wait cycle is
    // reached one count early; this puts the timeout flag exactly BUSY_WAIT
    // cycles after the tx_dv cycle.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BUSY_WAIT - 2);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [N_SYS-1:0]     r_slot_full;
    logic [7:0]           r_slot_addr    [N_SYS];
    logic [7:0]           r_slot_buysell [N_SYS];
    logic [31:0]          r_slot_ts      [N_SYS];
    logic [N_SYS-1:0]     r_drop_err;
    logic                 r_timeout_err;
    logic [7:0]           r_tx_addr;
    logic [7:0]           r_tx_buysell;
    logic [31:0]          r_tx_ts;
    logic                 r_tx_dv;

    logic                 w_found;
    logic [c_PTR_W-1:0]   w_winner;
    logic [c_PTR_W-1:0]   w_idx;
    logic                 w_grant;
    logic [N_SYS-1:0]     w_grant_vec;

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= N_SYS; k++) begin
            w_idx = c_PTR_W'((int'(r_rr_ptr) + k) % N_SYS);
            if (!w_found && r_slot_full[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // A grant only happens from IDLE while the UART is not busy.
    always_comb begin
        w_grant = (r_state == ST_IDLE) && w_found && !tx_busy;
        for (int i = 0; i < N_SYS; i++) begin
            w_grant_vec[i] = w_grant && (w_winner == c_PTR_W'(i));
        end
    end

    // Slot capture/release and per-channel drop flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_full <= '0;
            r_drop_err  <= '0;
            for (int i = 0; i < N_SYS; i++) begin
                r_slot_addr[i]    <= '0;
                r_slot_buysell[i] <= '0;
                r_slot_ts[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < N_SYS; i++) begin
                // A slot being granted this cycle is free to take a new order.
                if (in_dv[i] && (!r_slot_full[i] || w_grant_vec[i])) begin
                    r_slot_addr[i]    <= in_addr[8*i +: 8];
                    r_slot_buysell[i] <= in_buysell[8*i +: 8];
                    r_slot_ts[i]      <= in_timestamp[32*i +: 32];
                    r_slot_full[i]    <= 1'b1;
                end else if (w_grant_vec[i]) begin
                    r_slot_full[i]    <= 1'b0;
                end

                // Set wins over clear.
                if (in_dv[i] && r_slot_full[i] && !w_grant_vec[i]) begin
                    r_drop_err[i] <= 1'b1;
                end else if (clr_err) begin
                    r_drop_err[i] <= 1'b0;
                end
            end
        end
    end

    // Transmit FSM: grant, strobe, then track the UART busy handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= c_PTR_RST;
            r_cnt         <= '0;
            r_tx_addr     <= '0;
            r_tx_buysell  <= '0;
            r_tx_ts       <= '0;
            r_tx_dv       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tx_dv <= 1'b0;
            if (clr_err) begin
                r_timeout_err <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_tx_addr    <= r_slot_addr[w_winner];
                        r_tx_buysell <= r_slot_buysell[w_winner];
                        r_tx_ts      <= r_slot_ts[w_winner];
                        r_rr_ptr     <= w_winner;
                        r_tx_dv      <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign slot_full    = r_slot_full;
    assign tx_addr      = r_tx_addr;
    assign tx_buysell   = r_tx_buysell;
    assign tx_timestamp = r_tx_ts;
    assign tx_dv        = r_tx_dv;
    assign drop_err     = r_drop_err;
    assign timeout_err  = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_order_tx_arbiter.sv
// ============================================================================
// Module   : tb_order_tx_arbiter
// Brief    : Self-checking bench for order_tx_arbiter: directed scenarios plus
//            a randomized phase scored against per-channel order queues.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_order_tx_arbiter;

    localparam int N_SYS     = 2;
    localparam int BUSY_WAIT = 8;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [7:0]  bs;
        logic [31:0] ts;
    } tx_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   in_addr = '0;
    logic [15:0]   in_buysell = '0;
    logic [63:0]   in_timestamp = '0;
    logic [1:0]    in_dv = '0;
    logic [1:0]    slot_full;
    logic [7:0]    tx_addr;
    logic [7:0]    tx_buysell;
    logic [31:0]   tx_timestamp;
    logic          tx_dv;
    logic          tx_busy;
    logic          clr_err = 1'b0;
    logic [1:0]    drop_err;
    logic          timeout_err;

    int  n_checks = 0;
    int  n_err    = 0;
    int  cyc      = 0;
    tx_t txq[$];

    // UART model controls
    logic m_busy = 1'b0;
    logic force_busy = 1'b0;
    bit   m_en = 1'b1;
    bit   m_rand = 1'b0;
    int   m_delay = 1;
    int   m_hold = 10;
    int   m_phase = 0;
    int   m_cnt = 0;
    int   busy_fall_cyc = 0;

    assign tx_busy = m_busy | force_busy;

    order_tx_arbiter #(.N_SYS(N_SYS), .BUSY_WAIT(BUSY_WAIT)) dut (
        .clk(clk), .reset(reset),
        .in_addr(in_addr), .in_buysell(in_buysell), .in_timestamp(in_timestamp),
        .in_dv(in_dv), .slot_full(slot_full),
        .tx_addr(tx_addr), .tx_buysell(tx_buysell), .tx_timestamp(tx_timestamp),
        .tx_dv(tx_dv), .tx_busy(tx_busy), .clr_err(clr_err),
        .drop_err(drop_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every send strobe with its cycle number.
    always @(negedge clk) begin
        if (tx_dv === 1'b1) txq.push_back('{cyc: cyc, addr: tx_addr, bs: tx_buysell, ts: tx_timestamp});
    end

    // UART model: busy rises some cycles after tx_dv and holds for a while.
    always @(negedge clk) begin
        if (m_phase == 0) begin
            if (tx_dv === 1'b1 && m_en) begin
                m_cnt   = m_rand ? int'($urandom_range(1, 5)) : m_delay;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_busy  = 1'b1;
                m_cnt   = m_rand ? int'($urandom_range(1, 6)) : m_hold;
                m_phase = 2;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_busy        = 1'b0;
                m_phase       = 0;
                busy_fall_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [7:0] a, input logic [7:0] b, input logic [31:0] t);
        in_addr[8*ch +: 8]       = a;
        in_buysell[8*ch +: 8]    = b;
        in_timestamp[32*ch +: 32] = t;
    endtask

    // Called at a negedge; drives in_dv for one cycle and returns one negedge later.
    task automatic pulse(input logic [1:0] mask);
        in_dv = mask;
        @(negedge clk);
        in_dv = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_dv = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_wait();
        for (int i = 0; i < 100 && (m_phase != 0); i++) @(negedge clk);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_tx(input string tag, output tx_t r);
        for (int i = 0; i < 300 && txq.size() == 0; i++) @(negedge clk);
        n_checks++;
        assert (txq.size() != 0) else begin
            n_err++;
            $error("FAIL %s observed=no tx_dv expected=tx_dv strobe", tag);
        end
        if (txq.size() != 0) r = txq.pop_front();
        else r = '{cyc: 0, addr: 8'h0, bs: 8'h0, ts: 32'h0};
    endtask

    // Randomized-phase scoreboard: per-channel FIFOs of issued orders.
    logic [47:0] expq [2][$];
    bit          outst [2];
    int          last_tx_cyc = -1;

    task automatic score_txq();
        tx_t         r;
        int          ch;
        logic [47:0] exp;
        while (txq.size() != 0) begin
            r   = txq.pop_front();
            ch  = int'(r.addr[0]);
            exp = (expq[ch].size() != 0) ? expq[ch].pop_front() : 48'hDEAD_DEAD_DEAD;
            check("rand_order", 64'({r.addr, r.bs, r.ts}), 64'(exp));
            if (last_tx_cyc >= 0) check("rand_spacing", 64'(r.cyc - last_tx_cyc >= 4), 64'd1);
            last_tx_cyc = r.cyc;
            outst[ch]   = 1'b0;
        end
    endtask

    initial begin
        tx_t r, r2;
        int  c, t;
        logic [1:0] mask;

        @(negedge clk);
        do_reset();

        // ---------------- reset state ----------------
        check("rst_slot_full", 64'(slot_full), 64'd0);
        check("rst_tx_dv", 64'(tx_dv), 64'd0);
        check("rst_tx_data", 64'({tx_addr, tx_buysell, tx_timestamp}), 64'd0);
        check("rst_errs", 64'({drop_err, timeout_err}), 64'd0);

        // ---------------- single order ----------------
        m_delay = 1; m_hold = 10;
        c = cyc;
        set_ch(0, 8'h00, 8'h01, 32'h0000_1234);
        pulse(2'b01);
        check("single_slot_full", 64'(slot_full), 64'h1);
        @(negedge clk);
        check("single_tx_dv", 64'(tx_dv), 64'd1);
        check("single_slot_clr", 64'(slot_full), 64'h0);
        check("single_data", 64'({tx_addr, tx_buysell, tx_timestamp}), 64'h00_01_0000_1234);
        wait_tx("single_wait", r);
        check("single_latency", 64'(r.cyc - c), 64'd2);
        idle_wait();
        repeat (10) @(negedge clk);
        check("single_count", 64'(txq.size()), 64'd0);

        // ---------------- fairness ----------------
        do_reset();
        set_ch(0, 8'h10, 8'h01, 32'h100);
        set_ch(1, 8'h11, 8'h02, 32'h101);
        pulse(2'b11);
        wait_tx("fair_w1", r);
        wait_tx("fair_w2", r2);
        check("fair_order1", 64'({r.ts, r2.ts}), {32'h100, 32'h101});
        idle_wait();
        set_ch(0, 8'h10, 8'h01, 32'h102);
        set_ch(1, 8'h11, 8'h02, 32'h103);
        pulse(2'b11);
        wait_tx("fair_w3", r);
        wait_tx("fair_w4", r2);
        check("fair_order2", 64'({r.ts, r2.ts}), {32'h102, 32'h103});
        idle_wait();

        // ---------------- overflow ----------------
        force_busy = 1'b1;
        set_ch(1, 8'h21, 8'h02, 32'hA);
        pulse(2'b10);
        repeat (2) @(negedge clk);
        check("ovf_no_drop_yet", 64'(drop_err), 64'd0);
        set_ch(1, 8'h21, 8'h02, 32'hB);
        pulse(2'b10);
        check("ovf_drop_err", 64'(drop_err), 64'b10);
        check("ovf_slot_full", 64'(slot_full), 64'b10);
        force_busy = 1'b0;
        wait_tx("ovf_wait", r);
        check("ovf_sent_A", 64'(r.ts), 64'hA);
        idle_wait();
        repeat (10) @(negedge clk);
        check("ovf_B_dropped", 64'(txq.size()), 64'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("ovf_clr", 64'(drop_err), 64'd0);

        // ---------------- same-cycle refill ----------------
        set_ch(0, 8'h30, 8'h01, 32'h200);
        pulse(2'b01);
        set_ch(0, 8'h30, 8'h01, 32'h201);
        pulse(2'b01);
        check("refill_slot_full", 64'(slot_full), 64'b01);
        check("refill_tx_dv", 64'(tx_dv), 64'd1);
        wait_tx("refill_w1", r);
        wait_tx("refill_w2", r2);
        check("refill_order", 64'({r.ts, r2.ts}), {32'h200, 32'h201});
        check("refill_spacing", 64'(r2.cyc - r.cyc >= 4), 64'd1);
        check("refill_no_drop", 64'(drop_err), 64'd0);
        idle_wait();

        // ---------------- timeout ----------------
        m_en = 1'b0;
        set_ch(0, 8'h40, 8'h01, 32'h300);
        pulse(2'b01);
        set_ch(1, 8'h41, 8'h02, 32'h301);
        pulse(2'b10);
        check("to_tx_dv", 64'(tx_dv), 64'd1);
        t = cyc;
        repeat (BUSY_WAIT - 1) @(negedge clk);
        check("to_not_early", 64'(timeout_err), 64'd0);
        @(negedge clk);
        check("to_set", 64'(timeout_err), 64'd1);
        m_en = 1'b1;
        wait_tx("to_w1", r);
        check("to_first", 64'(r.ts), 64'h300);
        wait_tx("to_w2", r2);
        check("to_next_sent", 64'(r2.ts), 64'h301);
        check("to_next_cyc", 64'(r2.cyc - t), 64'(BUSY_WAIT + 1));
        idle_wait();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("to_clr", 64'(timeout_err), 64'd0);

        // ---------------- reset during WAIT_DONE ----------------
        m_delay = 1; m_hold = 15;
        set_ch(0, 8'h50, 8'h01, 32'h400);
        pulse(2'b01);
        @(negedge clk);
        check("rwd_tx_dv", 64'(tx_dv), 64'd1);
        set_ch(1, 8'h51, 8'h02, 32'h4FF);
        pulse(2'b10);
        @(negedge clk);
        check("rwd_slot1_full", 64'(slot_full), 64'b10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rwd_rst_slots", 64'(slot_full), 64'd0);
        check("rwd_rst_tx", 64'({tx_dv, tx_addr, tx_buysell, tx_timestamp}), 64'd0);
        check("rwd_rst_errs", 64'({drop_err, timeout_err}), 64'd0);
        wait_tx("rwd_w0", r);
        check("rwd_pre_frame", 64'(r.ts), 64'h400);
        repeat (2) @(negedge clk);
        set_ch(1, 8'h51, 8'h02, 32'h401);
        pulse(2'b10);
        wait_tx("rwd_w1", r);
        check("rwd_new_order", 64'(r.ts), 64'h401);
        check("rwd_after_busy", 64'(r.cyc - busy_fall_cyc), 64'd1);
        idle_wait();
        repeat (10) @(negedge clk);
        check("rwd_no_stale", 64'(txq.size()), 64'd0);

        // ---------------- randomized phase ----------------
        do_reset();
        m_rand = 1'b1;
        last_tx_cyc = -1;
        for (int cy = 0; cy < 600; cy++) begin
            mask = 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                if (!outst[ch] && $urandom_range(0, 3) == 0) begin
                    logic [7:0]  a, b;
                    logic [31:0] ts;
                    a  = {7'($urandom), 1'(ch)};
                    b  = 8'($urandom);
                    ts = $urandom;
                    set_ch(ch, a, b, ts);
                    expq[ch].push_back({a, b, ts});
                    outst[ch] = 1'b1;
                    mask[ch]  = 1'b1;
                end
            end
            pulse(mask);
            score_txq();
        end
        for (int i = 0; i < 300 && (outst[0] || outst[1]); i++) begin
            @(negedge clk);
            score_txq();
        end
        check("rand_all_sent", 64'({expq[0].size(), expq[1].size()}), 64'd0);
        check("rand_no_errs", 64'({drop_err, timeout_err}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
